// File: rtl/md5_csa_add_pipe_if.sv
// Operand/result handshake bundle for md5_csa_add_pipe.
interface md5_csa_add_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic             in_mode;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] in_c;
   logic [WIDTH-1:0] in_d;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic [1:0]       out_ovf;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_mode, in_a, in_b, in_c, in_d, in_tag, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, out_tag
   );

   modport slave (
      input  in_valid, in_mode, in_a, in_b, in_c, in_d, in_tag, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, out_tag
   );
endinterface

// File: rtl/md5_csa_add_pipe.sv
// Pipelined 2/4-operand modular adder: 4:2 carry-save stage followed by
// NSLICE registered carry-propagate slices; the last slice is the output register.
module md5_csa_add_pipe #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8,
   parameter int TAG_W = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   md5_csa_add_pipe_if.slave    io
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int W2     = WIDTH + 2;

   // Stage j (0..NSLICE-1) holds S/C, lower j resolved slices and carry into slice j
   logic [W2-1:0]    s_q   [NSLICE];
   logic [W2-1:0]    c_q   [NSLICE];
   logic [WIDTH-1:0] r_q   [NSLICE];
   logic             cy_q  [NSLICE];
   logic             v_q   [NSLICE];
   logic [TAG_W-1:0] tag_q [NSLICE];

   logic [W2-1:0]    csa_s, csa_c;
   logic [SLICE:0]   slice_t [NSLICE];
   logic [WIDTH-1:0] res_r   [NSLICE];
   logic             res_cy  [NSLICE];
   logic [1:0]       ovf;
   logic             stall;

   assign stall       = io.out_valid && !io.out_ready;
   assign io.in_ready = !stall;

   // Two cascaded 3:2 compressors; dropping carries past W2 is exact since the sum fits in W2 bits
   always_comb begin : csa
      logic [W2-1:0] a, b, c, d, x1, y1;
      a      = {2'b00, io.in_a};
      b      = {2'b00, io.in_b};
      c      = io.in_mode ? {2'b00, io.in_c} : '0;
      d      = io.in_mode ? {2'b00, io.in_d} : '0;
      x1     = a ^ b ^ c;
      y1     = ((a & b) | (a & c) | (b & c)) << 1;
      csa_s  = x1 ^ y1 ^ d;
      csa_c  = ((x1 & y1) | (x1 & d) | (y1 & d)) << 1;
   end

   always_comb begin : resolve
      for (int unsigned j = 0; j < NSLICE; j++) begin
         slice_t[j] = {1'b0, s_q[j][j*SLICE +: SLICE]}
                    + {1'b0, c_q[j][j*SLICE +: SLICE]}
                    + {{SLICE{1'b0}}, cy_q[j]};
         res_r[j]   = r_q[j];
         res_r[j][j*SLICE +: SLICE] = slice_t[j][SLICE-1:0];
         res_cy[j]  = slice_t[j][SLICE];
      end
      ovf = s_q[NSLICE-1][W2-1:WIDTH] + c_q[NSLICE-1][W2-1:WIDTH]
          + {1'b0, res_cy[NSLICE-1]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned j = 0; j < NSLICE; j++) v_q[j] <= 1'b0;
         io.out_valid <= 1'b0;
         io.out_sum   <= '0;
         io.out_ovf   <= '0;
         io.out_tag   <= '0;
      end else if (!stall) begin
         v_q[0]   <= io.in_valid;
         s_q[0]   <= csa_s;
         c_q[0]   <= csa_c;
         r_q[0]   <= '0;
         cy_q[0]  <= 1'b0;
         tag_q[0] <= io.in_tag;
         for (int unsigned j = 1; j < NSLICE; j++) begin
            v_q[j]   <= v_q[j-1];
            s_q[j]   <= s_q[j-1];
            c_q[j]   <= c_q[j-1];
            r_q[j]   <= res_r[j-1];
            cy_q[j]  <= res_cy[j-1];
            tag_q[j] <= tag_q[j-1];
         end
         io.out_valid <= v_q[NSLICE-1];
         io.out_sum   <= res_r[NSLICE-1];
         io.out_ovf   <= ovf;
         io.out_tag   <= tag_q[NSLICE-1];
      end
   end
endmodule
